clock_control_logic_fanout: RTL and testbench

//  Clock-tree node controller for one gated clock slice that serves NUM_CHILDREN downstream requesters.
//  ORs the child requests into one upstream request. Sequences the slice enable with an acknowledge handshake.

---
 rtl/clock_control_pkg.sv | 50 +++++
 rtl/clock_control_logic_fanout_if.sv | 56 +++++
 rtl/clock_ack_synchroniser.sv | 36 +++
 rtl/clock_control_logic_fanout.sv | 174 +++++++++++++++++
 tb/tb_clock_control_logic_fanout.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_control_pkg.sv
// ----------------------------------------------------------------------------
// clock_control_pkg
//   Shared types for clock-tree node controllers.
//   - clk_node_state_t  : node sequencing state (7 states)
//   - clk_node_status_t : one-hot node status {silent, starting, ready, stopping},
//                         common to the fan-out and single-child controllers
//   - decode_status     : state -> status mapping
//   - holdoff_cnt_width : hold-off counter width, never less than 1 bit
// ----------------------------------------------------------------------------
package clock_control_pkg;

    typedef enum logic [2:0] {
        ST_SILENT     = 3'd0,
        ST_REQ_PARENT = 3'd1,
        ST_ENABLING   = 3'd2,
        ST_READY      = 3'd3,
        ST_HOLDOFF    = 3'd4,
        ST_DISABLING  = 3'd5,
        ST_RELEASE    = 3'd6
    } clk_node_state_t;

    typedef struct packed {
        logic silent;
        logic starting;
        logic ready;
        logic stopping;
    } clk_node_status_t;

    // Exactly one status bit is set for every encoding. The unused encoding
    // reports silent, matching the state the FSM recovers to from it.
    function automatic clk_node_status_t decode_status(clk_node_state_t s);
        clk_node_status_t st;
        st = '0;
        case (s)
            ST_SILENT:                   st.silent   = 1'b1;
            ST_REQ_PARENT, ST_ENABLING:  st.starting = 1'b1;
            ST_READY, ST_HOLDOFF:        st.ready    = 1'b1;
            ST_DISABLING, ST_RELEASE:    st.stopping = 1'b1;
            default:                     st.silent   = 1'b1;
        endcase
        return st;
    endfunction

    // $clog2(n+1) bits hold the values 0..n; a zero hold-off still needs a
    // 1-bit counter so that the register has a legal width.
    function automatic int unsigned holdoff_cnt_width(int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage : clock_control_pkg

// File: rtl/clock_control_logic_fanout_if.sv
// ----------------------------------------------------------------------------
// clock_control_logic_fanout_if
//   Signal bundle of one clock-tree node controller.
//   Parent side : parent_request (node->parent), parent_ready, parent_silent
//   Child side  : child_request (children->node), child_ready/silent/
//                 starting/stopping (node->children, replicated status)
//   Macro side  : async_enable (node->macro), async_enable_ack (asynchronous)
//   Error       : protocol_error (sticky)
//   Modports    : slave  - the node controller itself
//                 master - the environment around it (parent, children, macro)
// ----------------------------------------------------------------------------
interface clock_control_logic_fanout_if #(
    parameter int unsigned NUM_CHILDREN = 4
);

    logic                    parent_request;
    logic                    parent_ready;
    logic                    parent_silent;
    logic [NUM_CHILDREN-1:0] child_request;
    logic [NUM_CHILDREN-1:0] child_ready;
    logic [NUM_CHILDREN-1:0] child_silent;
    logic [NUM_CHILDREN-1:0] child_starting;
    logic [NUM_CHILDREN-1:0] child_stopping;
    logic                    async_enable;
    logic                    async_enable_ack;
    logic                    protocol_error;

    modport slave (
        input  parent_ready,
        input  parent_silent,
        input  child_request,
        input  async_enable_ack,
        output parent_request,
        output child_ready,
        output child_silent,
        output child_starting,
        output child_stopping,
        output async_enable,
        output protocol_error
    );

    modport master (
        output parent_ready,
        output parent_silent,
        output child_request,
        output async_enable_ack,
        input  parent_request,
        input  child_ready,
        input  child_silent,
        input  child_starting,
        input  child_stopping,
        input  async_enable,
        input  protocol_error
    );

endinterface : clock_control_logic_fanout_if

// File: rtl/clock_ack_synchroniser.sv
// ----------------------------------------------------------------------------
// clock_ack_synchroniser
//   Multi-flop synchroniser bringing an asynchronous acknowledge into the
//   clock domain. Reusable for any level-type asynchronous ack.
//   Ports:
//     clock   in  1  destination clock (rising edge)
//     reset   in  1  synchronous, active-high; clears the whole chain
//     async_i in  1  asynchronous level input
//     sync_o  out 1  async_i delayed by STAGES flops
//   Parameters:
//     STAGES  number of flops in the chain (>= 2)
// ----------------------------------------------------------------------------
module clock_ack_synchroniser #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value its neighbour held before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule : clock_ack_synchroniser

// File: rtl/clock_control_logic_fanout.sv
// ----------------------------------------------------------------------------
// clock_control_logic_fanout
//   Clock-tree node controller for one gated clock slice serving NUM_CHILDREN
//   downstream requesters. ORs child demand into one upstream request,
//   sequences the slice gate enable with an ack handshake, and holds the gate
//   open through short demand gaps with a stop hold-off counter.
//   Ports:
//     clock    in  1  node clock, rising edge
//     reset    in  1  synchronous, active-high
//     node_if  slave modport of clock_control_logic_fanout_if:
//       parent_request out, parent_ready in, parent_silent in,
//       child_request in [N], child_ready/silent/starting/stopping out [N],
//       async_enable out, async_enable_ack in (async), protocol_error out
//   Parameters:
//     NUM_CHILDREN     child channels (>= 1)
//     STOP_HOLDOFF     zero-demand cycles tolerated in READY (0 = stop at once)
//     ACK_SYNC_STAGES  synchroniser depth for async_enable_ack (>= 2)
//   Every output is a decode of registered state only; no input reaches an
//   output combinationally.
// ----------------------------------------------------------------------------
module clock_control_logic_fanout
    import clock_control_pkg::*;
#(
    parameter int unsigned NUM_CHILDREN    = 4,
    parameter int unsigned STOP_HOLDOFF    = 8,
    parameter int unsigned ACK_SYNC_STAGES = 2
) (
    input logic                          clock,
    input logic                          reset,
    clock_control_logic_fanout_if.slave  node_if
);

    localparam int unsigned CNT_W = holdoff_cnt_width(STOP_HOLDOFF);
    // First count loaded on entering HOLDOFF; the zero-count cycle is itself
    // one of the tolerated cycles, hence the -1.
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD =
        CNT_W'((STOP_HOLDOFF == 0) ? 0 : STOP_HOLDOFF - 1);

    clk_node_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             demand;
    logic             ack_s;
    clk_node_status_t status;

    assign demand = |node_if.child_request;

    clock_ack_synchroniser #(
        .STAGES (ACK_SYNC_STAGES)
    ) u_ack_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (node_if.async_enable_ack),
        .sync_o  (ack_s)
    );

    // ------------------------------------------------------------------
    // State, counter and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_SILENT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so that no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_SILENT: begin
                if (demand) begin
                    state_d = ST_REQ_PARENT;
                end
            end

            // No abort here: once the parent has been asked, the start
            // sequence completes even if demand disappears meanwhile.
            ST_REQ_PARENT: begin
                if (node_if.parent_ready) begin
                    state_d = ST_ENABLING;
                end
            end

            ST_ENABLING: begin
                if (ack_s) begin
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                if (!demand) begin
                    if (STOP_HOLDOFF == 0) begin
                        state_d = ST_DISABLING;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLDOFF_LOAD;
                    end
                end
            end

            // Returning demand wins over expiry; the count only runs down
            // while demand stays absent and stops at zero.
            ST_HOLDOFF: begin
                if (demand) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DISABLING;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DISABLING: begin
                if (!ack_s) begin
                    state_d = ST_RELEASE;
                end
            end

            // Demand raised here waits for the parent to be fully stopped;
            // SILENT then restarts the sequence cleanly.
            ST_RELEASE: begin
                if (node_if.parent_silent) begin
                    state_d = ST_SILENT;
                end
            end

            default: begin
                state_d = ST_SILENT;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky: losing the parent clock while the gate is (being) opened is a
    // protocol violation. It is reported only; sequencing ignores it.
    always_comb begin
        err_d = err_q;
        if (!node_if.parent_ready &&
            (state_q inside {ST_ENABLING, ST_READY, ST_HOLDOFF})) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure decodes of the state register
    // ------------------------------------------------------------------
    assign status = decode_status(state_q);

    assign node_if.parent_request = (state_q inside {ST_REQ_PARENT, ST_ENABLING,
                                                     ST_READY, ST_HOLDOFF,
                                                     ST_DISABLING});
    assign node_if.async_enable   = (state_q inside {ST_ENABLING, ST_READY,
                                                     ST_HOLDOFF});
    assign node_if.protocol_error = err_q;

    assign node_if.child_silent   = {NUM_CHILDREN{status.silent}};
    assign node_if.child_starting = {NUM_CHILDREN{status.starting}};
    assign node_if.child_ready    = {NUM_CHILDREN{status.ready}};
    assign node_if.child_stopping = {NUM_CHILDREN{status.stopping}};

endmodule : clock_control_logic_fanout

// File: tb/tb_clock_control_logic_fanout.sv
// ----------------------------------------------------------------------------
// tb_clock_control_logic_fanout
//   Table of per-cycle {inputs, expected outputs} for the default node
//   (STOP_HOLDOFF=8, 2 sync stages), followed by a hand-written sequence on a
//   second node with STOP_HOLDOFF=0.
// ----------------------------------------------------------------------------
module tb_clock_control_logic_fanout;

    localparam logic [1:0] C_SIL = 2'd0;
    localparam logic [1:0] C_ST  = 2'd1;
    localparam logic [1:0] C_RDY = 2'd2;
    localparam logic [1:0] C_STP = 2'd3;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       pr;
        logic       ps;
        logic       ack;
        logic       exp_preq;
        logic       exp_en;
        logic       exp_err;
        logic [1:0] exp_cls;
    } vec_t;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    clock_control_logic_fanout_if #(.NUM_CHILDREN(4)) bus ();
    clock_control_logic_fanout_if #(.NUM_CHILDREN(4)) bus0 ();

    clock_control_logic_fanout #(
        .NUM_CHILDREN    (4),
        .STOP_HOLDOFF    (8),
        .ACK_SYNC_STAGES (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .node_if (bus)
    );

    clock_control_logic_fanout #(
        .NUM_CHILDREN    (4),
        .STOP_HOLDOFF    (0),
        .ACK_SYNC_STAGES (2)
    ) dut0 (
        .clock   (clock),
        .reset   (reset),
        .node_if (bus0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] expect_word(logic preq, logic en,
                                                logic err, logic [1:0] cls);
        return {preq, en, err,
                {4{cls == C_SIL}}, {4{cls == C_ST}},
                {4{cls == C_RDY}}, {4{cls == C_STP}}};
    endfunction

    function automatic logic [18:0] observe_main();
        return {bus.parent_request, bus.async_enable, bus.protocol_error,
                bus.child_silent, bus.child_starting,
                bus.child_ready, bus.child_stopping};
    endfunction

    function automatic vec_t mk(string name, logic rst, logic [3:0] req,
                                logic pr, logic ps, logic ack, logic preq,
                                logic en, logic err, logic [1:0] cls);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.pr = pr; v.ps = ps;
        v.ack = ack; v.exp_preq = preq; v.exp_en = en; v.exp_err = err;
        v.exp_cls = cls;
        return v;
    endfunction

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.child_request = '0;  bus.parent_ready = 1'b0;
        bus.parent_silent = 1'b1; bus.async_enable_ack = 1'b0;
        bus0.child_request = '0; bus0.parent_ready = 1'b0;
        bus0.parent_silent = 1'b1; bus0.async_enable_ack = 1'b0;

        //          name           rst req     pr ps ack  preq en err cls
        vecs.push_back(mk("rst0",      1, 4'b0000, 0, 1, 0,   0, 0, 0, C_SIL));
        vecs.push_back(mk("rst1",      1, 4'b0000, 0, 1, 0,   0, 0, 0, C_SIL));
        // Start: child 1 requests, parent ready 2 cycles later, ack 3 after enable
        vecs.push_back(mk("t1_req",    0, 4'b0010, 0, 1, 0,   1, 0, 0, C_ST));
        vecs.push_back(mk("t1_wait",   0, 4'b0010, 0, 0, 0,   1, 0, 0, C_ST));
        vecs.push_back(mk("t1_pready", 0, 4'b0010, 1, 0, 0,   1, 1, 0, C_ST));
        vecs.push_back(mk("t1_en0",    0, 4'b0010, 1, 0, 0,   1, 1, 0, C_ST));
        vecs.push_back(mk("t1_en1",    0, 4'b0010, 1, 0, 0,   1, 1, 0, C_ST));
        vecs.push_back(mk("t1_ack0",   0, 4'b0010, 1, 0, 1,   1, 1, 0, C_ST));
        vecs.push_back(mk("t1_ack1",   0, 4'b0010, 1, 0, 1,   1, 1, 0, C_ST));
        vecs.push_back(mk("t1_ready",  0, 4'b0010, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t1_hold",   0, 4'b0010, 1, 0, 1,   1, 1, 0, C_RDY));
        // Short gap of 5 cycles, then child 3: gate stays open
        vecs.push_back(mk("t2_gap1",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t2_gap2",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t2_gap3",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t2_gap4",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t2_gap5",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t2_child3", 0, 4'b1000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t2_stay",   0, 4'b1000, 1, 0, 1,   1, 1, 0, C_RDY));
        // Long gap: gate drops on the 9th zero-demand edge
        vecs.push_back(mk("t3_gap1",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap2",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap3",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap4",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap5",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap6",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap7",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_gap8",   0, 4'b0000, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t3_disable",0, 4'b0000, 1, 0, 1,   1, 0, 0, C_STP));
        vecs.push_back(mk("t3_ackhi",  0, 4'b0000, 1, 0, 1,   1, 0, 0, C_STP));
        vecs.push_back(mk("t3_acklo0", 0, 4'b0000, 1, 0, 0,   1, 0, 0, C_STP));
        vecs.push_back(mk("t3_acklo1", 0, 4'b0000, 1, 0, 0,   1, 0, 0, C_STP));
        vecs.push_back(mk("t3_release",0, 4'b0000, 1, 0, 0,   0, 0, 0, C_STP));
        // Demand in RELEASE waits for parent_silent
        vecs.push_back(mk("t4_rel_req",0, 4'b0001, 0, 0, 0,   0, 0, 0, C_STP));
        vecs.push_back(mk("t4_rel_hld",0, 4'b0001, 0, 0, 0,   0, 0, 0, C_STP));
        vecs.push_back(mk("t4_silent", 0, 4'b0001, 0, 1, 0,   0, 0, 0, C_SIL));
        vecs.push_back(mk("t4_restart",0, 4'b0001, 0, 1, 0,   1, 0, 0, C_ST));
        // Back to READY, then lose parent_ready
        vecs.push_back(mk("t5_enable", 0, 4'b0001, 1, 0, 0,   1, 1, 0, C_ST));
        vecs.push_back(mk("t5_ack0",   0, 4'b0001, 1, 0, 1,   1, 1, 0, C_ST));
        vecs.push_back(mk("t5_ack1",   0, 4'b0001, 1, 0, 1,   1, 1, 0, C_ST));
        vecs.push_back(mk("t5_ready",  0, 4'b0001, 1, 0, 1,   1, 1, 0, C_RDY));
        vecs.push_back(mk("t5_lost",   0, 4'b0001, 0, 0, 1,   1, 1, 1, C_RDY));
        vecs.push_back(mk("t5_back",   0, 4'b0001, 1, 0, 1,   1, 1, 1, C_RDY));
        vecs.push_back(mk("t5_sticky", 0, 4'b0001, 1, 0, 1,   1, 1, 1, C_RDY));
        vecs.push_back(mk("t5_clear",  1, 4'b0000, 1, 0, 0,   0, 0, 0, C_SIL));
        // Reset in the middle of ENABLING
        vecs.push_back(mk("t6_req",    0, 4'b0100, 1, 0, 0,   1, 0, 0, C_ST));
        vecs.push_back(mk("t6_enab",   0, 4'b0100, 1, 0, 0,   1, 1, 0, C_ST));
        vecs.push_back(mk("t6_reset",  1, 4'b0100, 1, 0, 0,   0, 0, 0, C_SIL));
        vecs.push_back(mk("t6_idle",   0, 4'b0000, 0, 1, 0,   0, 0, 0, C_SIL));

        foreach (vecs[i]) begin
            @(negedge clock);
            reset                = vecs[i].rst;
            bus.child_request    = vecs[i].req;
            bus.parent_ready     = vecs[i].pr;
            bus.parent_silent    = vecs[i].ps;
            bus.async_enable_ack = vecs[i].ack;
            @(posedge clock);
            #1;
            check(vecs[i].name, 32'(observe_main()),
                  32'(expect_word(vecs[i].exp_preq, vecs[i].exp_en,
                                  vecs[i].exp_err, vecs[i].exp_cls)));
        end

        // STOP_HOLDOFF=0 node: parent and macro respond at once.
        @(negedge clock);
        bus0.child_request    = 4'b0001;
        bus0.parent_ready     = 1'b1;
        bus0.parent_silent    = 1'b0;
        bus0.async_enable_ack = 1'b1;
        for (int n = 0; n < 20 && bus0.child_ready !== 4'hF; n++) begin
            @(posedge clock);
            #1;
        end
        check("h0_ready", 32'(bus0.child_ready), 32'hF);
        check("h0_enable", 32'(bus0.async_enable), 32'h1);

        @(negedge clock);
        bus0.child_request = 4'b0000;
        @(posedge clock);
        #1;
        check("h0_stop_1edge", 32'({bus0.child_stopping, bus0.async_enable,
                                   bus0.parent_request}), {25'd0, 4'hF, 1'b0, 1'b1});

        @(negedge clock);
        bus0.async_enable_ack = 1'b0;
        bus0.parent_ready     = 1'b0;
        bus0.parent_silent    = 1'b1;
        for (int n = 0; n < 20 && bus0.child_silent !== 4'hF; n++) begin
            @(posedge clock);
            #1;
        end
        check("h0_silent", 32'({bus0.child_silent, bus0.parent_request,
                               bus0.protocol_error}), {26'd0, 4'hF, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_clock_control_logic_fanout
